// File: rtl/krnl_rtl_trial_a_axi_read_issuer.sv
// AXI4 read-address issuer: splits one read command into fixed-size AR bursts,
// throttled by an outstanding-burst counter, and pulses ctrl_done once all bursts retire.
module krnl_rtl_trial_a_axi_read_issuer #(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_DATA_WIDTH      = 512,
  parameter int C_LEN_WIDTH       = 32,
  parameter int C_BURST_LEN       = 16,
  parameter int C_MAX_OUTSTANDING = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ctrl_start,
  input  logic [C_ADDR_WIDTH-1:0] ctrl_addr,
  input  logic [C_LEN_WIDTH-1:0]  ctrl_xfer_beats,
  output logic                    ctrl_busy,
  output logic                    ctrl_done,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  output logic [C_ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]              m_arlen,
  input  logic                    burst_done
);

  localparam int                      LP_OUT_W      = $clog2(C_MAX_OUTSTANDING) + 1;
  localparam int                      LP_BL_LOG2    = $clog2(C_BURST_LEN);
  localparam logic [C_LEN_WIDTH-1:0]  LP_LEN_MASK   = C_LEN_WIDTH'(C_BURST_LEN - 1);
  localparam logic [LP_OUT_W-1:0]     LP_MAX_OUT    = LP_OUT_W'(C_MAX_OUTSTANDING);
  localparam logic [C_ADDR_WIDTH-1:0] LP_ADDR_STEP  = C_ADDR_WIDTH'(C_BURST_LEN * C_DATA_WIDTH / 8);
  localparam logic [7:0]              LP_FULL_ARLEN = 8'(C_BURST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  r_state, w_state_next;
  logic [C_LEN_WIDTH-1:0]  r_bursts_left, w_bursts_left_next;
  logic [7:0]              r_last_len, w_last_len_next;
  logic [LP_OUT_W-1:0]     r_outstanding, w_outstanding_next;
  logic                    r_arvalid, w_arvalid_next;
  logic [C_ADDR_WIDTH-1:0] r_araddr, w_araddr_next;
  logic [7:0]              r_arlen, w_arlen_next;
  logic                    r_busy, w_busy_next;
  logic                    r_done, w_done_next;

  logic                    w_hs;
  logic                    w_retire;
  logic                    w_room;
  logic [C_LEN_WIDTH-1:0]  w_start_bursts;
  logic [7:0]              w_start_last_len;

  assign w_hs     = r_arvalid & m_arready;
  // A completion with nothing in flight is dropped so the counter cannot underflow.
  assign w_retire = burst_done & (r_outstanding != {LP_OUT_W{1'b0}});
  assign w_room   = (w_outstanding_next < LP_MAX_OUT);

  assign w_start_bursts   = (ctrl_xfer_beats >> LP_BL_LOG2)
                          + {{(C_LEN_WIDTH-1){1'b0}}, |(ctrl_xfer_beats & LP_LEN_MASK)};
  assign w_start_last_len = 8'((ctrl_xfer_beats - C_LEN_WIDTH'(1)) & LP_LEN_MASK);

  // In-flight burst count: handshake adds one, retired burst removes one, both cancel.
  always_comb begin
    w_outstanding_next = r_outstanding;
    case ({w_hs, w_retire})
      2'b10:   w_outstanding_next = r_outstanding + LP_OUT_W'(1);
      2'b01:   w_outstanding_next = r_outstanding - LP_OUT_W'(1);
      default: w_outstanding_next = r_outstanding;
    endcase
  end

  // Next-state and next registered-output decisions.
  always_comb begin
    w_state_next       = r_state;
    w_bursts_left_next = r_bursts_left;
    w_last_len_next    = r_last_len;
    w_arvalid_next     = r_arvalid;
    w_araddr_next      = r_araddr;
    w_arlen_next       = r_arlen;
    w_busy_next        = r_busy;
    w_done_next        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ctrl_start) begin
          w_busy_next        = 1'b1;
          w_araddr_next      = ctrl_addr;
          w_bursts_left_next = w_start_bursts;
          w_last_len_next    = w_start_last_len;
          if (ctrl_xfer_beats == {C_LEN_WIDTH{1'b0}}) begin
            w_state_next   = S_DRAIN;
            w_arvalid_next = 1'b0;
            w_arlen_next   = 8'd0;
          end else begin
            w_state_next   = S_ISSUE;
            w_arvalid_next = 1'b1;
            w_arlen_next   = (w_start_bursts == C_LEN_WIDTH'(1)) ? w_start_last_len : LP_FULL_ARLEN;
          end
        end else begin
          w_state_next   = S_IDLE;
          w_arvalid_next = 1'b0;
        end
      end
      S_ISSUE: begin
        if (w_hs) begin
          w_araddr_next      = r_araddr + LP_ADDR_STEP;
          w_bursts_left_next = r_bursts_left - C_LEN_WIDTH'(1);
          w_arlen_next       = (r_bursts_left == C_LEN_WIDTH'(2)) ? r_last_len : LP_FULL_ARLEN;
          if (r_bursts_left == C_LEN_WIDTH'(1)) begin
            w_state_next   = S_DRAIN;
            w_arvalid_next = 1'b0;
          end else begin
            w_arvalid_next = w_room;
          end
        end else begin
          // Without a handshake the count can only fall, so a raised valid stays raised.
          w_arvalid_next = w_room;
        end
      end
      S_DRAIN: begin
        if (w_outstanding_next == {LP_OUT_W{1'b0}}) begin
          w_done_next  = 1'b1;
          w_busy_next  = 1'b0;
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_DRAIN;
        end
      end
      default: begin
        w_state_next   = S_IDLE;
        w_arvalid_next = 1'b0;
        w_busy_next    = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_bursts_left <= {C_LEN_WIDTH{1'b0}};
      r_last_len    <= 8'd0;
      r_outstanding <= {LP_OUT_W{1'b0}};
      r_arvalid     <= 1'b0;
      r_araddr      <= {C_ADDR_WIDTH{1'b0}};
      r_arlen       <= 8'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_bursts_left <= w_bursts_left_next;
      r_last_len    <= w_last_len_next;
      r_outstanding <= w_outstanding_next;
      r_arvalid     <= w_arvalid_next;
      r_araddr      <= w_araddr_next;
      r_arlen       <= w_arlen_next;
      r_busy        <= w_busy_next;
      r_done        <= w_done_next;
    end
  end

  assign ctrl_busy = r_busy;
  assign ctrl_done = r_done;
  assign m_arvalid = r_arvalid;
  assign m_araddr  = r_araddr;
  assign m_arlen   = r_arlen;

endmodule

// File: tb/tb_krnl_rtl_trial_a_axi_read_issuer.sv
// Self-checking bench for krnl_rtl_trial_a_axi_read_issuer: vector table, directed
// corner sequences and randomized transfers against a burst-list reference model.
module tb_krnl_rtl_trial_a_axi_read_issuer;

  localparam int MAXO = 4;

  logic        clk;
  logic        rst;
  logic        ctrl_start;
  logic [63:0] ctrl_addr;
  logic [31:0] ctrl_xfer_beats;
  logic        ctrl_busy;
  logic        ctrl_done;
  logic        m_arvalid;
  logic        m_arready;
  logic [63:0] m_araddr;
  logic [7:0]  m_arlen;
  logic        burst_done;

  krnl_rtl_trial_a_axi_read_issuer #(
    .C_ADDR_WIDTH(64), .C_DATA_WIDTH(512), .C_LEN_WIDTH(32),
    .C_BURST_LEN(16), .C_MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst), .ctrl_start(ctrl_start), .ctrl_addr(ctrl_addr),
    .ctrl_xfer_beats(ctrl_xfer_beats), .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .burst_done(burst_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp;
  int          n_bad;
  int          ar_count;
  logic [63:0] last_addr;
  logic [7:0]  last_len;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] beats;
    bit          glitch;
    int          exp_n;
    logic [63:0] exp_last_addr;
    logic [7:0]  exp_last_len;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transfer checked cycle by cycle against the burst list derived from (addr, beats).
  task automatic run_xfer(input logic [63:0] addr, input logic [31:0] beats,
                          input int rdy_pct, input int bd_pct, input bit glitch);
    int          nb, rem, mout, idx;
    bit          exp_v, hs, bd, fin;
    logic [63:0] exp_addr;
    logic [7:0]  exp_len;
    nb = int'((beats + 32'd15) / 32'd16);
    ar_count = 0;
    exp_addr = 64'd0;
    exp_len  = 8'd0;
    ctrl_addr = addr; ctrl_xfer_beats = beats; ctrl_start = 1'b1;
    tick();
    ctrl_start = 1'b0;
    chk("busy_after_start", 64'(ctrl_busy), 64'd1);
    rem = nb; mout = 0; idx = 0; fin = 1'b0;
    if (nb == 0) begin
      chk("zero_len_done_t1", 64'(ctrl_done), 64'd0);
      chk("zero_len_no_ar", 64'(m_arvalid), 64'd0);
      tick();
      chk("zero_len_done_t2", 64'(ctrl_done), 64'd1);
      chk("zero_len_busy_t2", 64'(ctrl_busy), 64'd0);
      fin = 1'b1;
    end else begin
      for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
        exp_v = (rem > 0) && (mout < MAXO);
        chk("arvalid", 64'(m_arvalid), 64'(exp_v));
        chk("busy", 64'(ctrl_busy), 64'd1);
        chk("done_early", 64'(ctrl_done), 64'd0);
        if (exp_v) begin
          exp_addr = addr + 64'(idx) * 64'd1024;
          exp_len  = (idx == nb - 1) ? 8'((beats - 32'd1) % 32'd16) : 8'd15;
          chk("araddr", m_araddr, exp_addr);
          chk("arlen", 64'(m_arlen), 64'(exp_len));
        end
        m_arready  = ($urandom_range(0, 99) < rdy_pct);
        bd         = (mout > 0) && ($urandom_range(0, 99) < bd_pct);
        burst_done = bd;
        if (glitch && cyc == 1) begin
          ctrl_start = 1'b1; ctrl_addr = 64'h9000; ctrl_xfer_beats = 32'd7;
        end
        hs = exp_v && m_arready;
        tick();
        ctrl_start = 1'b0; m_arready = 1'b0; burst_done = 1'b0;
        if (hs) begin
          last_addr = exp_addr; last_len = exp_len;
          ar_count++; idx++; rem--; mout++;
        end
        if (bd) mout--;
        if (rem == 0 && mout == 0) begin
          chk("done", 64'(ctrl_done), 64'd1);
          chk("busy_at_done", 64'(ctrl_busy), 64'd0);
          fin = 1'b1;
        end
      end
    end
    chk("xfer_completed_in_budget", 64'(fin), 64'd1);
    tick();
    chk("done_one_cycle", 64'(ctrl_done), 64'd0);
    chk("idle_arvalid", 64'(m_arvalid), 64'd0);
  endtask

  initial begin
    int          n;
    logic [31:0] rb;
    logic [63:0] ra;
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; ctrl_start = 1'b0; ctrl_addr = 64'd0; ctrl_xfer_beats = 32'd0;
    m_arready = 1'b0; burst_done = 1'b0;
    last_addr = 64'd0; last_len = 8'd0; ar_count = 0;

    vecs[0] = '{64'h1000, 32'd5, 1'b0, 1, 64'h1000, 8'd4};
    vecs[1] = '{64'h0, 32'd35, 1'b0, 3, 64'h800, 8'd2};
    vecs[2] = '{64'h0, 32'd16, 1'b0, 1, 64'h0, 8'd15};
    vecs[3] = '{64'h4000, 32'd17, 1'b1, 2, 64'h4400, 8'd0};
    vecs[4] = '{64'h5000, 32'd0, 1'b0, 0, 64'h0, 8'd0};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FC00, 32'd33, 1'b0, 3, 64'h400, 8'd0};
    vecs[6] = '{64'h2000, 32'd64, 1'b1, 4, 64'h2C00, 8'd15};

    repeat (3) tick();
    rst = 1'b0;
    chk("rst_arvalid", 64'(m_arvalid), 64'd0);
    chk("rst_araddr", m_araddr, 64'd0);
    chk("rst_arlen", 64'(m_arlen), 64'd0);
    chk("rst_busy", 64'(ctrl_busy), 64'd0);
    chk("rst_done", 64'(ctrl_done), 64'd0);
    tick();

    for (int v = 0; v < 7; v++) begin
      run_xfer(vecs[v].addr, vecs[v].beats, 100, 50, vecs[v].glitch);
      chk("vec_ar_count", 64'(ar_count), 64'(vecs[v].exp_n));
      if (vecs[v].exp_n > 0) begin
        chk("vec_last_araddr", last_addr, vecs[v].exp_last_addr);
        chk("vec_last_arlen", 64'(last_len), 64'(vecs[v].exp_last_len));
      end
    end

    // Outstanding limit: four ARs, stall, one retirement re-arms exactly one AR.
    ctrl_addr = 64'h0; ctrl_xfer_beats = 32'd160; ctrl_start = 1'b1;
    tick();
    ctrl_start = 1'b0; m_arready = 1'b1; n = 0;
    for (int c = 0; c < 8; c++) begin
      if (m_arvalid) n++;
      tick();
    end
    chk("limit_ar_count", 64'(n), 64'd4);
    chk("limit_arvalid_low", 64'(m_arvalid), 64'd0);
    burst_done = 1'b1;
    tick();
    burst_done = 1'b0;
    chk("limit_rearm", 64'(m_arvalid), 64'd1);
    chk("limit_rearm_addr", m_araddr, 64'h1000);
    tick();
    chk("limit_again_full", 64'(m_arvalid), 64'd0);
    m_arready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;

    // Backpressure stall, then retirement coincident with a handshake.
    ctrl_addr = 64'h10000; ctrl_xfer_beats = 32'd48; ctrl_start = 1'b1;
    tick();
    ctrl_start = 1'b0; m_arready = 1'b1;
    chk("bp_first_addr", m_araddr, 64'h10000);
    tick();
    m_arready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("bp_stall_valid", 64'(m_arvalid), 64'd1);
      chk("bp_stall_addr", m_araddr, 64'h10400);
      chk("bp_stall_len", 64'(m_arlen), 64'd15);
      if (c < 3) tick();
    end
    m_arready = 1'b1; burst_done = 1'b1;
    tick();
    burst_done = 1'b0;
    chk("bp_third_valid", 64'(m_arvalid), 64'd1);
    chk("bp_third_addr", m_araddr, 64'h10800);
    chk("bp_third_len", 64'(m_arlen), 64'd15);
    tick();
    m_arready = 1'b0;
    chk("bp_drain_valid", 64'(m_arvalid), 64'd0);
    burst_done = 1'b1;
    tick();
    burst_done = 1'b0;
    chk("bp_one_left_done", 64'(ctrl_done), 64'd0);
    chk("bp_one_left_busy", 64'(ctrl_busy), 64'd1);
    tick();
    chk("bp_waiting_done", 64'(ctrl_done), 64'd0);
    burst_done = 1'b1;
    tick();
    burst_done = 1'b0;
    chk("bp_final_done", 64'(ctrl_done), 64'd1);
    chk("bp_final_busy", 64'(ctrl_busy), 64'd0);
    tick();
    chk("bp_done_pulse", 64'(ctrl_done), 64'd0);

    // Reset with three bursts in flight and a fourth presented.
    ctrl_addr = 64'h20000; ctrl_xfer_beats = 32'd160; ctrl_start = 1'b1;
    tick();
    ctrl_start = 1'b0; m_arready = 1'b1;
    repeat (3) tick();
    m_arready = 1'b0;
    chk("mid_rst_pre_valid", 64'(m_arvalid), 64'd1);
    chk("mid_rst_pre_addr", m_araddr, 64'h20C00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 64'(m_arvalid), 64'd0);
    chk("mid_rst_busy", 64'(ctrl_busy), 64'd0);
    chk("mid_rst_done", 64'(ctrl_done), 64'd0);
    tick();
    chk("mid_rst_no_done", 64'(ctrl_done), 64'd0);
    run_xfer(64'h3000, 32'd20, 100, 50, 1'b0);
    chk("post_rst_ar_count", 64'(ar_count), 64'd2);
    chk("post_rst_last_len", 64'(last_len), 64'd3);

    // Randomized transfers with random ready and retirement timing.
    for (int r = 0; r < 25; r++) begin
      rb = 32'($urandom_range(0, 90));
      ra = {$urandom(), $urandom()} & ~64'h3FF;
      run_xfer(ra, rb, int'($urandom_range(20, 100)), int'($urandom_range(10, 90)),
               ($urandom_range(0, 3) == 0));
      chk("rand_ar_count", 64'(ar_count), 64'((rb + 32'd15) / 32'd16));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
